// File: rtl/pic_pkg.sv
// Shared constants and types for the PIC-style fetch unit and its return stack.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pic_pkg;

    localparam int PC_W    = 11;
    localparam int INSTR_W = 14;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    // Opcode match patterns
    localparam logic [2:0] OP_GOTO      = 3'b101;   // IR[13:11]
    localparam logic [2:0] OP_CALL      = 3'b100;   // IR[13:11]
    localparam logic [3:0] OP_RETLW     = 4'b1101;  // IR[13:10]
    localparam instr_t     INSTR_RETURN = 14'h0008;
    localparam instr_t     INSTR_RETFIE = 14'h0009;
    localparam instr_t     INSTR_NOP    = 14'h0000;

    localparam pc_t PC_ONE = 11'd1;

    // What the fetch stage does at the next rising edge
    typedef enum logic [2:0] {
        ACT_FETCH  = 3'd0,
        ACT_HOLD   = 3'd1,
        ACT_JUMP   = 3'd2,
        ACT_RETURN = 3'd3,
        ACT_SKIP   = 3'd4
    } fetch_act_t;

    function automatic logic is_return(input instr_t instr);
        return (instr == INSTR_RETURN) || (instr == INSTR_RETFIE) ||
               (instr[13:10] == OP_RETLW);
    endfunction

endpackage

// File: rtl/call_stack.sv
// Circular return-address stack; full push overwrites oldest, empty pop wraps; both set sticky err.
// Latency: pop_data is combinational (top entry); push/pop take effect at the rising edge.
// Backpressure: none; push and pop are always accepted (push wins if both asserted).
// Ports: clk, rst_n (async active-low), push/push_data, pop/pop_data, err (sticky).
module call_stack
    import pic_pkg::*;
#(
    parameter int STACK_DEPTH = 8   // power of two, at least 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  pc_t  push_data,
    input  logic pop,
    output pc_t  pop_data,
    output logic err
);

    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W:0]   CNT_FULL = STACK_DEPTH[PTR_W:0];

    pc_t              mem [STACK_DEPTH];
    logic [PTR_W-1:0] sp;       // next free slot; wraps naturally
    logic [PTR_W:0]   count;    // entries held, saturates at STACK_DEPTH
    logic [PTR_W-1:0] top_idx;

    // With a power-of-two depth the pointer wraps for free, so an empty pop
    // reads the slot just below sp, and a full push lands on the oldest entry.
    assign top_idx  = sp - PTR_ONE;
    assign pop_data = mem[top_idx];

    // Entry contents are not reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[sp] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp    <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (push) begin
            sp <= sp + PTR_ONE;
            if (count == CNT_FULL) begin
                err <= 1'b1;
            end else begin
                count <= count + CNT_ONE;
            end
        end else if (pop) begin
            sp <= top_idx;
            if (count == '0) begin
                err <= 1'b1;
            end else begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/program_fetch.sv
// Two-stage instruction fetch (PC -> ROM -> IR) with GOTO/CALL/return/skip handling.
// Latency: ROM word appears in ir_out one edge after its address; taken branch costs one bubble.
// Backpressure: stall_in freezes PC, IR, ir_valid and the return stack for that cycle.
// Ports: clk, rst_n (async active-low), Rom_addr_out/Rom_data_in (combinational ROM),
//        stall_in, skip_in from execute; ir_out/ir_valid_out to execute; stack_err_out sticky.
module program_fetch
    import pic_pkg::*;
#(
    parameter int STACK_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    Rom_addr_out,
    input  logic [INSTR_W-1:0] Rom_data_in,
    input  logic               stall_in,
    input  logic               skip_in,
    output logic [INSTR_W-1:0] ir_out,
    output logic               ir_valid_out,
    output logic               stack_err_out
);

    pc_t        pc;
    instr_t     ir;
    logic       ir_valid;
    pc_t        pc_inc;
    pc_t        ret_addr;
    logic       is_jump;
    logic       is_call;
    logic       is_ret;
    logic       push;
    logic       pop;
    fetch_act_t act;

    // 11-bit wrap from 7FF to 000 falls out of the vector width
    assign pc_inc = pc + PC_ONE;

    // Bubbles never decode as control flow
    assign is_call = ir_valid && (ir[13:11] == OP_CALL);
    assign is_jump = ir_valid && ((ir[13:11] == OP_GOTO) || (ir[13:11] == OP_CALL));
    assign is_ret  = ir_valid && is_return(ir);

    always_comb begin
        act = ACT_FETCH;
        if (stall_in) begin
            act = ACT_HOLD;
        end else if (is_jump) begin
            act = ACT_JUMP;
        end else if (is_ret) begin
            act = ACT_RETURN;
        end else if (ir_valid && skip_in) begin
            act = ACT_SKIP;
        end
    end

    // PC already points past the CALL, so it is the return address
    assign push = (act == ACT_JUMP) && is_call;
    assign pop  = (act == ACT_RETURN);

    call_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_call_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (pc),
        .pop       (pop),
        .pop_data  (ret_addr),
        .err       (stack_err_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= '0;
            ir       <= INSTR_NOP;
            ir_valid <= 1'b0;
        end else begin
            case (act)
                ACT_HOLD: begin
                    pc       <= pc;
                    ir       <= ir;
                    ir_valid <= ir_valid;
                end
                ACT_JUMP: begin
                    pc       <= ir[PC_W-1:0];
                    ir       <= INSTR_NOP;
                    ir_valid <= 1'b0;
                end
                ACT_RETURN: begin
                    pc       <= ret_addr;
                    ir       <= INSTR_NOP;
                    ir_valid <= 1'b0;
                end
                ACT_SKIP: begin
                    // Word fetched this cycle is the skipped one; drop it
                    pc       <= pc_inc;
                    ir       <= INSTR_NOP;
                    ir_valid <= 1'b0;
                end
                default: begin
                    pc       <= pc_inc;
                    ir       <= Rom_data_in;
                    ir_valid <= 1'b1;
                end
            endcase
        end
    end

    assign Rom_addr_out = pc;
    assign ir_out       = ir;
    assign ir_valid_out = ir_valid;

endmodule

// File: tb/tb_program_fetch.sv
// Self-checking bench for program_fetch: directed steps with a scoreboard queue.
// Each step pushes the expected post-edge state, clocks once, then pops and compares.
module tb_program_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] rom_addr;
    logic [13:0] rom_data;
    logic        stall;
    logic        skip;
    logic [13:0] ir;
    logic        ir_valid;
    logic        stack_err;

    logic [13:0] rom [0:2047];

    typedef struct packed {
        logic [10:0] addr;
        logic [13:0] ir;
        logic        vld;
        logic        err;
    } exp_t;

    exp_t  sb[$];
    int    checks   = 0;
    int    failures = 0;
    string cur_test = "init";

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    program_fetch #(
        .STACK_DEPTH (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Rom_addr_out  (rom_addr),
        .Rom_data_in   (rom_data),
        .stall_in      (stall),
        .skip_in       (skip),
        .ir_out        (ir),
        .ir_valid_out  (ir_valid),
        .stack_err_out (stack_err)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [13:0] filler(input int a);
        return 14'h3F00 | 14'(a & 255);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%0h expected=%0h", cur_test, tag, obs, exp);
        end
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 2048; i++) rom[i] = filler(i);
    endtask

    // Drive inputs, clock one edge, compare against the queued expectation
    task automatic step(input logic st, input logic sk, input logic [10:0] a,
                        input logic [13:0] i, input logic v, input logic e);
        exp_t x;
        x = '{addr: a, ir: i, vld: v, err: e};
        sb.push_back(x);
        stall = st;
        skip  = sk;
        @(posedge clk);
        @(negedge clk);
        x = sb.pop_front();
        chk("addr", 16'(rom_addr), 16'(x.addr));
        chk("ir", 16'(ir), 16'(x.ir));
        chk("vld", 16'(ir_valid), 16'(x.vld));
        chk("err", 16'(stack_err), 16'(x.err));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_addr"}, 16'(rom_addr), 16'h0000);
        chk({tag, "_ir"}, 16'(ir), 16'h0000);
        chk({tag, "_vld"}, 16'(ir_valid), 16'h0000);
        chk({tag, "_err"}, 16'(stack_err), 16'h0000);
    endtask

    // Called at a negedge (or at start); leaves the bench at a negedge with reset released
    task automatic do_reset();
        stall = 1'b0;
        skip  = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_async");
        @(posedge clk);
        @(negedge clk);
        check_reset_state("rst_held");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        stall = 1'b0;
        skip  = 1'b0;
        fill_rom();
        #2;

        // Sequential fetch after reset
        cur_test = "seq";
        rom[0] = 14'h3044;
        for (int k = 1; k < 8; k++) rom[k] = 14'h3E00 | 14'(k);
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b0, 11'(k), (k == 1) ? 14'h3044 : (14'h3E00 | 14'(k - 1)), 1'b1, 1'b0);
        end

        // GOTO 5 at address 2
        cur_test = "goto";
        fill_rom();
        rom[2] = 14'h2805;
        do_reset();
        step(1'b0, 1'b0, 11'h001, filler(0), 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h002, filler(1), 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h003, 14'h2805, 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h005, 14'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 11'h006, filler(5), 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h007, filler(6), 1'b1, 1'b0);

        // CALL 0x10 at 3, RETURN at 0x10
        cur_test = "call_ret";
        fill_rom();
        rom[3]     = 14'h2010;
        rom[11'h10] = 14'h0008;
        do_reset();
        step(1'b0, 1'b0, 11'h001, filler(0), 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h002, filler(1), 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h003, filler(2), 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h004, 14'h2010, 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h010, 14'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 11'h011, 14'h0008, 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h004, 14'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 11'h005, filler(4), 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h006, filler(5), 1'b1, 1'b0);

        // Nine nested CALLs, then RETURNs unwinding past the overwritten entry
        cur_test = "overflow";
        fill_rom();
        rom[0] = 14'h2100;
        for (int k = 0; k < 8; k++) begin
            rom[11'h100 + 11'(16 * k)] = 14'h2000 | 14'(11'h110 + 11'(16 * k));
            rom[11'h101 + 11'(16 * k)] = 14'h0008;
        end
        rom[11'h180] = 14'h0008;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            int s;
            int t;
            s = (k == 0) ? 0 : (16'h100 + 16 * (k - 1));
            t = 16'h100 + 16 * k;
            step(1'b0, 1'b0, 11'(s + 1), 14'h2000 | 14'(t), 1'b1, 1'b0);
            step(1'b0, 1'b0, 11'(t), 14'h0000, 1'b0, (k == 8));
        end
        step(1'b0, 1'b0, 11'h181, 14'h0008, 1'b1, 1'b1);
        for (int j = 0; j < 8; j++) begin
            int r;
            r = 16'h171 - 16 * j;
            step(1'b0, 1'b0, 11'(r), 14'h0000, 1'b0, 1'b1);
            step(1'b0, 1'b0, 11'(r + 1), 14'h0008, 1'b1, 1'b1);
        end
        // Oldest return address (0x001) was lost; wrapped pop yields 0x171 again
        step(1'b0, 1'b0, 11'h171, 14'h0000, 1'b0, 1'b1);

        // Stall for 3 cycles with GOTO in IR
        cur_test = "stall";
        fill_rom();
        rom[2] = 14'h2805;
        do_reset();
        step(1'b0, 1'b0, 11'h001, filler(0), 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h002, filler(1), 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h003, 14'h2805, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 11'h003, 14'h2805, 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h005, 14'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 11'h006, filler(5), 1'b1, 1'b0);

        // PC wraps from 7FF to 000
        cur_test = "wrap";
        fill_rom();
        rom[0] = 14'h2FFE;
        do_reset();
        step(1'b0, 1'b0, 11'h001, 14'h2FFE, 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h7FE, 14'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 11'h7FF, filler(11'h7FE), 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h000, filler(11'h7FF), 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h001, 14'h2FFE, 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h7FE, 14'h0000, 1'b0, 1'b0);

        // Skip on the instruction from address 6
        cur_test = "skip";
        fill_rom();
        do_reset();
        for (int k = 1; k <= 7; k++) step(1'b0, 1'b0, 11'(k), filler(k - 1), 1'b1, 1'b0);
        step(1'b0, 1'b1, 11'h008, 14'h0000, 1'b0, 1'b0);
        // skip on a bubble is ignored
        step(1'b0, 1'b1, 11'h009, filler(8), 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h00A, filler(9), 1'b1, 1'b0);
        // stall outranks skip
        step(1'b1, 1'b1, 11'h00A, filler(9), 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h00B, filler(10), 1'b1, 1'b0);

        // Reset while a CALL sits in IR; the push must never happen
        cur_test = "rst_mid_call";
        fill_rom();
        rom[3] = 14'h2010;
        do_reset();
        step(1'b0, 1'b0, 11'h001, filler(0), 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h002, filler(1), 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h003, filler(2), 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'h004, 14'h2010, 1'b1, 1'b0);
        rom[0] = 14'h0008;
        do_reset();
        step(1'b0, 1'b0, 11'h001, 14'h0008, 1'b1, 1'b0);
        // Stack must be empty, so this RETURN underflows
        stall = 1'b0;
        skip  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("underflow_err", 16'(stack_err), 16'h0001);
        chk("underflow_vld", 16'(ir_valid), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
